// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and the processor fetch path.
// The PC reset value must come from DEFAULT_BASE_ADDR so loader and core agree.
package loader_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h7600_0000;
  localparam int          DEFAULT_MAX_WORDS = 256;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes LSB-first into a 32-bit word and keeps the running
// XOR of every data byte seen since the last clear.
module word_assembler (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  xor_o,
  output logic        last_byte_o
);

  logic [1:0]  byteIdxQ;
  logic [31:0] wordQ;
  logic [7:0]  xorQ;

  // Shifting right places the first byte of a word in bits [7:0] after four bytes.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      byteIdxQ <= 2'd0;
      wordQ    <= 32'd0;
      xorQ     <= 8'd0;
    end else if (clear_i) begin
      byteIdxQ <= 2'd0;
      wordQ    <= 32'd0;
      xorQ     <= 8'd0;
    end else if (byte_en_i) begin
      byteIdxQ <= byteIdxQ + 2'd1;
      wordQ    <= {byte_i, wordQ[31:8]};
      xorQ     <= xorQ ^ byte_i;
    end
  end

  assign word_o      = wordQ;
  assign xor_o       = xorQ;
  assign last_byte_o = (byteIdxQ == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Byte-serial program loader: parses a length/data/checksum frame, writes the
// words into instruction memory and holds the CPU in reset until verified.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_o
);

  loader_state_e stateQ;
  logic [15:0]   lenQ;
  logic [15:0]   lenD;
  logic [15:0]   idxQ;
  logic          byteFire;
  logic          restart;
  logic          dataByte;
  logic [31:0]   asmWord;
  logic [7:0]    asmXor;
  logic          asmLast;

  assign byte_ready_o = (stateQ == LEN_LO) || (stateQ == LEN_HI) ||
                        (stateQ == DATA)   || (stateQ == CSUM);
  assign byteFire     = byte_valid_i && byte_ready_o;
  assign restart      = start_i && ((stateQ == IDLE) || (stateQ == DONE) ||
                                    (stateQ == ERROR));
  assign dataByte     = byteFire && (stateQ == DATA);
  assign lenD         = {byte_i, lenQ[7:0]};

  word_assembler u_word_assembler (
    .clk_i      (clk_i),
    .reset      (reset),
    .clear_i    (restart),
    .byte_en_i  (dataByte),
    .byte_i     (byte_i),
    .word_o     (asmWord),
    .xor_o      (asmXor),
    .last_byte_o(asmLast)
  );

  // idx doubles as the written-word count, so words_o needs no separate register.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
      lenQ   <= 16'd0;
      idxQ   <= 16'd0;
    end else begin
      case (stateQ)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            stateQ <= LEN_LO;
            idxQ   <= 16'd0;
          end
        end
        LEN_LO: begin
          if (byteFire) begin
            lenQ[7:0] <= byte_i;
            stateQ    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (byteFire) begin
            lenQ[15:8] <= byte_i;
            if ((lenD == 16'd0) || (lenD > 16'(MAX_WORDS))) stateQ <= ERROR;
            else                                             stateQ <= DATA;
          end
        end
        DATA: begin
          if (dataByte && asmLast) stateQ <= WRITE;
        end
        WRITE: begin
          idxQ <= idxQ + 16'd1;
          if ((idxQ + 16'd1) == lenQ) stateQ <= CSUM;
          else                        stateQ <= DATA;
        end
        CSUM: begin
          if (byteFire) stateQ <= (byte_i == asmXor) ? DONE : ERROR;
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign mem_we_o    = (stateQ == WRITE);
  assign mem_addr_o  = BASE_ADDR + {14'd0, idxQ, 2'b00};
  assign mem_wd_o    = asmWord;
  assign cpu_reset_o = (stateQ != DONE);
  assign done_o      = (stateQ == DONE);
  assign error_o     = (stateQ == ERROR);
  assign words_o     = idxQ;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them whenever mem_we_o is seen.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h7600_0000;
  localparam int          MAXW = 256;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic        mem_we_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] words_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  logic [31:0] frameWords[$];
  logic [31:0] lastAddr = 32'd0;
  int          checks = 0;
  int          failures = 0;

  program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .start_i     (start_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wd_o    (mem_wd_o),
    .mem_we_o    (mem_we_o),
    .cpu_reset_o (cpu_reset_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .words_o     (words_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Every write must match the oldest outstanding expectation, with no byte taken.
  always @(negedge clk_i) begin
    wr_t e;
    if (mem_we_o === 1'b1) begin
      checkOutput("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write addr=%h data=%h expected=none",
                 mem_addr_o, mem_wd_o);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_addr", mem_addr_o, e.addr);
        checkOutput("write_data", mem_wd_o, e.data);
      end
      lastAddr = mem_addr_o;
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int gaps;
    int guard;
    bit accepted;
    gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    if (gaps > 0) begin
      byte_valid_i = 1'b0;
      repeat (gaps) begin
        @(posedge clk_i);
        #1;
      end
    end
    byte_i       = b;
    byte_valid_i = 1'b1;
    guard        = 0;
    accepted     = 1'b0;
    while (!accepted && guard < 100) begin
      @(negedge clk_i);
      accepted = byte_ready_o;
      @(posedge clk_i);
      #1;
      guard++;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL byte_timeout actual=not_accepted expected=accepted byte=%h", b);
    end
  endtask

  task automatic pulseStart();
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Reference rules: words land at BASE+4*i, CSUM is the XOR of all data bytes,
  // a length outside 1..MAXW fails right after the header.
  task automatic applyStimulus(input int len, input bit badCsum, input int gapMax);
    logic [7:0]  csum;
    logic [31:0] w;
    logic [15:0] len16;
    bit          lenOk;
    bit          expDone;
    len16   = 16'(len);
    lenOk   = (len >= 1) && (len <= MAXW);
    expDone = lenOk && !badCsum;
    pulseStart();
    checkOutput("start_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    checkOutput("start_words", {16'd0, words_o}, 32'd0);
    checkOutput("start_done", {31'd0, done_o}, 32'd0);
    sendByte(len16[7:0], gapMax);
    sendByte(len16[15:8], gapMax);
    if (lenOk) begin
      csum = 8'd0;
      for (int i = 0; i < len; i++) begin
        w = frameWords[i];
        expQ.push_back('{addr: BASE + 32'(4 * i), data: w});
        for (int k = 0; k < 4; k++) begin
          csum = csum ^ w[8*k +: 8];
          sendByte(w[8*k +: 8], gapMax);
        end
      end
      sendByte(csum ^ {7'd0, badCsum}, gapMax);
    end
    byte_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("end_done", {31'd0, done_o}, {31'd0, expDone});
    checkOutput("end_error", {31'd0, error_o}, {31'd0, !expDone});
    checkOutput("end_cpu_reset", {31'd0, cpu_reset_o}, {31'd0, !expDone});
    checkOutput("end_words", {16'd0, words_o}, lenOk ? 32'(len) : 32'd0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic randomWords(input int n);
    frameWords.delete();
    for (int i = 0; i < n; i++) frameWords.push_back($urandom);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
    checkOutput({tag, "_addr"}, mem_addr_o, BASE);
    checkOutput({tag, "_wd"}, mem_wd_o, 32'd0);
    checkOutput({tag, "_cpu_reset"}, {31'd0, cpu_reset_o}, 32'd1);
    checkOutput({tag, "_done"}, {31'd0, done_o}, 32'd0);
    checkOutput({tag, "_error"}, {31'd0, error_o}, 32'd0);
    checkOutput({tag, "_words"}, {16'd0, words_o}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkResetValues("reset");
    @(posedge clk_i);
    #1;
    reset = 1'b0;

    $display("[TB] happy path");
    frameWords.delete();
    frameWords.push_back(32'h0000_0013);
    frameWords.push_back(32'hDEAD_BEEF);
    applyStimulus(2, 1'b0, 0);

    $display("[TB] reload from DONE");
    randomWords(1);
    applyStimulus(1, 1'b0, 0);

    $display("[TB] bad checksum");
    frameWords.delete();
    frameWords.push_back(32'h0000_0013);
    frameWords.push_back(32'hDEAD_BEEF);
    applyStimulus(2, 1'b1, 0);

    $display("[TB] length violations");
    applyStimulus(0, 1'b0, 0);
    applyStimulus(MAXW + 1, 1'b0, 0);

    $display("[TB] maximum length, continuous valid");
    randomWords(MAXW);
    applyStimulus(MAXW, 1'b0, 0);
    checkOutput("max_last_addr", lastAddr, BASE + 32'(4 * (MAXW - 1)));

    $display("[TB] random frames with idle gaps");
    for (int f = 0; f < 5; f++) begin
      int n;
      n = int'($urandom_range(8, 1));
      randomWords(n);
      applyStimulus(n, ($urandom_range(3, 0) == 0), 3);
    end

    $display("[TB] reset mid-DATA");
    randomWords(2);
    pulseStart();
    sendByte(8'd2, 0);
    sendByte(8'd0, 0);
    for (int k = 0; k < 3; k++) sendByte(8'hA0 + 8'(k), 0);
    byte_valid_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("async_reset");
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    reset = 1'b0;
    applyStimulus(2, 1'b0, 1);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
